// File: rtl/irq_responder.sv
// Interrupt responder: synchronizes a level IRQ, queues XOR'd comparator
// operands in a small FIFO and runs a request/acknowledge handshake.
module irq_responder #(
    parameter logic [7:0] PORT_STATUS = 8'h00,
    parameter logic [7:0] PORT_DATA   = 8'h01,
    parameter int         DEPTH       = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       irq_in,
    input  logic [7:0] data_1,
    input  logic [7:0] data_2,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    input  logic       interrupt_ack,
    output logic [7:0] in_port,
    output logic       interrupt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] FULL_CNT = 4'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        SERV
    } state_t;

    state_t state, state_next;

    logic          sync_1, sync_2, sync_3;
    logic          evt;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [3:0]    count;
    logic          ovf;
    logic          empty, full;
    logic          pop, push, ovf_set, status_rd;

    // sync_3 holds the previous synchronizer output for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            sync_3 <= 1'b0;
        end else begin
            sync_1 <= irq_in;
            sync_2 <= sync_1;
            sync_3 <= sync_2;
        end
    end

    assign evt       = sync_2 & ~sync_3;
    assign empty     = (count == 4'd0);
    assign full      = (count == FULL_CNT);
    assign pop       = read_strobe & (port_id == PORT_DATA) & ~empty;
    assign push      = evt & (~full | pop);
    assign ovf_set   = evt & full & ~pop;
    assign status_rd = read_strobe & (port_id == PORT_STATUS);

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= data_1 ^ data_2;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= 4'd0;
            ovf   <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 4'd1;
            else if (pop && !push)
                count <= count - 4'd1;
            if (ovf_set)
                ovf <= 1'b1;
            else if (status_rd)
                ovf <= 1'b0;
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (port_id == PORT_DATA)
            in_port = empty ? 8'h00 : mem[rptr];
        else if (port_id == PORT_STATUS)
            in_port = {ovf, empty, full, 1'b0, count};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            interrupt <= 1'b0;
        end else begin
            state     <= state_next;
            interrupt <= (state_next == PEND);
        end
    end

    // Acknowledge only matters while a request is pending
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (!empty) state_next = PEND;
            PEND: if (interrupt_ack) state_next = SERV;
            SERV: if (empty) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_irq_responder.sv
// Randomized and directed bench for irq_responder against a
// queue-based behavioural model.
module tb_irq_responder;
    localparam logic [7:0] PS = 8'h00;
    localparam logic [7:0] PD = 8'h01;
    localparam int DEPTH = 4;
    localparam int M_IDLE = 0;
    localparam int M_PEND = 1;
    localparam int M_SERV = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       irq_in;
    logic [7:0] data_1, data_2, port_id;
    logic       read_strobe, interrupt_ack;
    logic [7:0] in_port;
    logic       interrupt;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] q[$];
    logic       m_ovf;
    logic [2:0] hist;
    int         ph;

    irq_responder #(
        .PORT_STATUS(PS),
        .PORT_DATA  (PD),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_in       (irq_in),
        .data_1       (data_1),
        .data_2       (data_2),
        .port_id      (port_id),
        .read_strobe  (read_strobe),
        .interrupt_ack(interrupt_ack),
        .in_port      (in_port),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        q.delete();
        m_ovf = 1'b0;
        hist = 3'b000;
        ph = M_IDLE;
    endfunction

    // Event at an edge: irq seen high two edges ago, low three edges ago
    function automatic void model_edge();
        logic ev, pop, ovr;
        int sz;
        ev = hist[1] && !hist[2];
        hist = {hist[1:0], irq_in};
        sz = q.size();
        pop = read_strobe && (port_id == PD) && (sz > 0);
        case (ph)
            M_IDLE: if (sz != 0) ph = M_PEND;
            M_PEND: if (interrupt_ack) ph = M_SERV;
            default: if (sz == 0) ph = M_IDLE;
        endcase
        ovr = 1'b0;
        if (pop) void'(q.pop_front());
        if (ev) begin
            if (sz < DEPTH || pop) q.push_back(data_1 ^ data_2);
            else ovr = 1'b1;
        end
        if (ovr) m_ovf = 1'b1;
        else if (read_strobe && port_id == PS) m_ovf = 1'b0;
    endfunction

    function automatic logic [7:0] model_port(input logic [7:0] pid);
        int sz;
        sz = q.size();
        if (pid == PD) return (sz > 0) ? q[0] : 8'h00;
        if (pid == PS)
            return {m_ovf, sz == 0, sz == DEPTH, 1'b0, 4'(sz)};
        return 8'h00;
    endfunction

    task automatic drive(input logic irq, input logic [7:0] pid,
                         input logic rs, input logic ack);
        irq_in = irq;
        port_id = pid;
        read_strobe = rs;
        interrupt_ack = ack;
        #1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic tick(input logic irq, input logic [7:0] pid,
                        input logic rs, input logic ack);
        drive(irq, pid, rs, ack);
        clk_edge();
    endtask

    task automatic set_data(input logic [7:0] v);
        data_1 = 8'($urandom);
        data_2 = data_1 ^ v;
    endtask

    // One event: irq high for two cycles; push lands on the third edge
    task automatic fire(input logic [7:0] v);
        set_data(v);
        tick(1'b1, 8'h7E, 1'b0, 1'b0);
        tick(1'b1, 8'h7E, 1'b0, 1'b0);
        tick(1'b0, 8'h7E, 1'b0, 1'b0);
        tick(1'b0, 8'h7E, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input logic irq);
        irq_in = irq;
        port_id = 8'h7E;
        read_strobe = 1'b0;
        interrupt_ack = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clk_edge();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        data_1 = 8'h12;
        data_2 = 8'h34;
        drive(1'b0, PD, 1'b1, 1'b0);
        #5;
        n_checks++;
        if (in_port !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data got %h exp 00", in_port);
        end
        drive(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (in_port !== 8'h40) begin
            n_fail++;
            $display("FAIL reset_status got %h exp 40", in_port);
        end
        n_checks++;
        if (interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq got %b exp 0", interrupt);
        end
        apply_reset(1'b0);
        drive(1'b0, PD, 1'b1, 1'b0);
        clk_edge();
        drive(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (in_port !== 8'h40) begin
            n_fail++;
            $display("FAIL empty_read_count got %h exp 40", in_port);
        end
        drive(1'b0, 8'h7E, 1'b0, 1'b0);
        n_checks++;
        if (in_port !== 8'h00) begin
            n_fail++;
            $display("FAIL unmapped got %h exp 00", in_port);
        end
    endtask

    task automatic test_single_event();
        apply_reset(1'b0);
        data_1 = 8'hA5;
        data_2 = 8'h0F;
        for (int i = 0; i < 5; i++) begin
            tick(i < 4, 8'h7E, 1'b0, 1'b0);
            if (interrupt === 1'b1) break;
        end
        n_checks++;
        if (interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rise got %b exp 1", interrupt);
        end
        tick(1'b0, 8'h7E, 1'b0, 1'b1);
        n_checks++;
        if (interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_ack got %b exp 0", interrupt);
        end
        drive(1'b0, PD, 1'b1, 1'b0);
        n_checks++;
        if (in_port !== 8'hAA) begin
            n_fail++;
            $display("FAIL single_data got %h exp aa", in_port);
        end
        clk_edge();
        tick(1'b0, PS, 1'b0, 1'b0);
        tick(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (in_port !== 8'h40 || interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle got %h/%b exp 40/0", in_port, interrupt);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [5];
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            vals[i] = 8'(8'h11 * (i + 1));
            fire(vals[i]);
        end
        drive(1'b0, PS, 1'b1, 1'b0);
        n_checks++;
        if (in_port !== 8'hA4) begin
            n_fail++;
            $display("FAIL ovf_status got %h exp a4", in_port);
        end
        clk_edge();
        drive(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (in_port !== 8'h24) begin
            n_fail++;
            $display("FAIL ovf_cleared got %h exp 24", in_port);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, PD, 1'b1, 1'b0);
            n_checks++;
            if (in_port !== vals[i]) begin
                n_fail++;
                $display("FAIL ovf_data%0d got %h exp %h", i, in_port, vals[i]);
            end
            clk_edge();
        end
        tick(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (interrupt !== 1'b1 || in_port !== 8'h40) begin
            n_fail++;
            $display("FAIL drained_pend got %b/%h exp 1/40", interrupt, in_port);
        end
        tick(1'b0, PS, 1'b0, 1'b1);
        tick(1'b0, PS, 1'b0, 1'b0);
        tick(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL drained_idle got %b exp 0", interrupt);
        end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] vals [5];
        apply_reset(1'b0);
        for (int i = 0; i < 5; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) fire(vals[i]);
        set_data(vals[4]);
        tick(1'b1, 8'h7E, 1'b0, 1'b0);
        tick(1'b1, 8'h7E, 1'b0, 1'b0);
        drive(1'b0, PD, 1'b1, 1'b0);
        clk_edge();
        drive(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (in_port !== 8'h24) begin
            n_fail++;
            $display("FAIL pushpop_status got %h exp 24", in_port);
        end
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, PD, 1'b1, 1'b0);
            n_checks++;
            if (in_port !== vals[i]) begin
                n_fail++;
                $display("FAIL pushpop_data%0d got %h exp %h", i, in_port, vals[i]);
            end
            clk_edge();
        end
    endtask

    task automatic test_serv_event();
        apply_reset(1'b0);
        fire(8'h3C);
        tick(1'b0, 8'h7E, 1'b0, 1'b1);
        fire(8'hC3);
        drive(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (interrupt !== 1'b0 || in_port !== 8'h02) begin
            n_fail++;
            $display("FAIL serv_queue got %b/%h exp 0/02", interrupt, in_port);
        end
        tick(1'b0, PD, 1'b1, 1'b1);
        drive(1'b0, PD, 1'b1, 1'b0);
        n_checks++;
        if (in_port !== 8'hC3 || interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL serv_second got %h/%b exp c3/0", in_port, interrupt);
        end
        clk_edge();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 8'h7E, 1'b0, 1'b0);
            n_checks++;
            if (interrupt !== 1'b0) begin
                n_fail++;
                $display("FAIL serv_after got %b exp 0", interrupt);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset(1'b0);
        fire(8'h01);
        fire(8'h02);
        fire(8'h03);
        tick(1'b0, PS, 1'b0, 1'b1);
        drive(1'b0, PS, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (interrupt !== 1'b0 || in_port !== 8'h40) begin
            n_fail++;
            $display("FAIL midreset got %b/%h exp 0/40", interrupt, in_port);
        end
        apply_reset(1'b0);
        for (int i = 0; i < 8; i++) tick(1'b0, PS, 1'b0, 1'b0);
        n_checks++;
        if (interrupt !== 1'b0 || in_port !== 8'h40) begin
            n_fail++;
            $display("FAIL midreset_after got %b/%h exp 0/40", interrupt, in_port);
        end
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) tick(1'b1, PS, 1'b0, 1'b0);
        n_checks++;
        if (interrupt !== 1'b1 || in_port !== 8'h01) begin
            n_fail++;
            $display("FAIL release_high got %b/%h exp 1/01", interrupt, in_port);
        end
    endtask

    task automatic test_random();
        logic irq;
        logic [7:0] pid;
        logic [7:0] exp;
        apply_reset(1'b0);
        irq = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 3) == 0) irq = ~irq;
            if (!irq) begin
                data_1 = 8'($urandom);
                data_2 = 8'($urandom);
            end
            case ($urandom_range(0, 3))
                0: pid = PS;
                1: pid = PD;
                2: pid = 8'h7E;
                default: pid = 8'($urandom);
            endcase
            drive(irq, pid, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0);
            exp = model_port(pid);
            n_checks++;
            if (in_port !== exp) begin
                n_fail++;
                $display("FAIL rand_port c=%0d got %h exp %h", c, in_port, exp);
            end
            clk_edge();
            n_checks++;
            if (interrupt !== (ph == M_PEND)) begin
                n_fail++;
                $display("FAIL rand_irq c=%0d got %b exp %b", c, interrupt, ph == M_PEND);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_overflow();
        test_full_pushpop();
        test_serv_event();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
